// File: rtl/sprite_loader_pkg.sv
// Shared types and constants for the sprite pixel loader and the display path.
// Frame states, sprite select codes, RGB333 field positions and a pixel-pack helper.
package sprite_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEL    = 3'd1,
    ST_PIX_HI = 3'd2,
    ST_PIX_LO = 3'd3,
    ST_CHK    = 3'd4
  } state_e;

  localparam logic SPR_FROG = 1'b0;
  localparam logic SPR_CAR  = 1'b1;

  localparam int PIX_W     = 9;
  localparam int RGB_R_MSB = 8;
  localparam int RGB_R_LSB = 6;
  localparam int RGB_G_MSB = 5;
  localparam int RGB_G_LSB = 3;
  localparam int RGB_B_MSB = 2;
  localparam int RGB_B_LSB = 0;

  // HI byte contributes only its bit 0 as pixel[8]; LO byte is pixel[7:0].
  function automatic logic [PIX_W-1:0] rgb333_pack(input logic hi_bit, input logic [7:0] lo);
    return {hi_bit, lo};
  endfunction

endpackage

// File: rtl/sprite_loader_if.sv
// Byte-stream input and sprite-memory write port of the sprite loader.
// i_Byte_Valid is a one-cycle strobe with no ready: a byte is consumed in exactly the cycle
// its valid is high, and the loader never stalls the sender.
interface sprite_loader_if #(
  parameter int ADDR_W = 10
);
  import sprite_loader_pkg::*;

  logic              i_Byte_Valid;
  logic [7:0]        i_Byte;
  logic              o_Wr_En;
  logic              o_Wr_Sel;
  logic [ADDR_W-1:0] o_Wr_Addr;
  logic [PIX_W-1:0]  o_Wr_Data;
  logic              o_Busy;
  logic              o_Done;
  logic              o_Error;
  state_e            dbg_state;

  modport master (
    output i_Byte_Valid, i_Byte,
    input  o_Wr_En, o_Wr_Sel, o_Wr_Addr, o_Wr_Data, o_Busy, o_Done, o_Error, dbg_state
  );

  modport slave (
    input  i_Byte_Valid, i_Byte,
    output o_Wr_En, o_Wr_Sel, o_Wr_Addr, o_Wr_Data, o_Busy, o_Done, o_Error, dbg_state
  );

endinterface

// File: rtl/sprite_loader_timeout.sv
// Inter-byte watchdog: loadable down-counter that expires a fixed number of idle clocks
// after the last byte, held at its reload value while cleared.
module sprite_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  // Reload is two short of the limit so the abort lands exactly TIMEOUT_CYCLES clocks
  // after the last byte, once the registered error output is counted in.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = !clear && !load && (cnt_q == '0);

endmodule

// File: rtl/sprite_loader.sv
// Sprite loader: parses SYNC/SEL/pixel-pair frames from the UART byte stream and writes
// RGB333 pixels row-major into the frog or car sprite memory. Checksum byte: SPRITE_LOADER_CHECKSUM_EN.
module sprite_loader
  import sprite_loader_pkg::*;
#(
  parameter int         TILE_SIZE      = 32,
  parameter int         ADDR_W         = 10,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 2500000
) (
  input  logic           i_Clk,
  input  logic           i_Rst_L,
  sprite_loader_if.slave bus
);

  localparam int                NPIX     = TILE_SIZE * TILE_SIZE;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic              sel_q, sel_d;
  logic              hi_q, hi_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              timeout_expire;
  logic              byte_v;
  logic [7:0]        byte_in;
`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`else
  logic              last_q, last_d;
`endif

  assign byte_v  = bus.i_Byte_Valid;
  assign byte_in = bus.i_Byte;

  sprite_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .clear (state_q == ST_IDLE),
    .load  (byte_v),
    .expire(timeout_expire)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    hi_d    = hi_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    error_d = 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`else
    // Without a checksum, completion trails the final write strobe by one cycle.
    last_d  = 1'b0;
    done_d  = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (byte_v && byte_in == SYNC_BYTE) begin
          state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        if (byte_v) begin
          if (byte_in[7:1] == 7'd0) begin
            sel_d   = byte_in[0];
            cnt_d   = '0;
            state_d = ST_PIX_HI;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_PIX_HI: begin
        if (byte_v) begin
          hi_d    = byte_in[0];
          state_d = ST_PIX_LO;
        end
      end
      ST_PIX_LO: begin
        if (byte_v) begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q;
          data_d  = rgb333_pack(hi_q, byte_in);
          if (cnt_q == LAST_PIX) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_IDLE;
            last_d  = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_PIX_HI;
          end
        end
      end
`ifdef SPRITE_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (byte_v) begin
          if (byte_in == chk_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef SPRITE_LOADER_CHECKSUM_EN
    // Running XOR over SEL and every pixel byte; a SYNC in IDLE starts it afresh.
    if (byte_v) begin
      if (state_q == ST_IDLE) begin
        chk_d = '0;
      end else if (state_q != ST_CHK) begin
        chk_d = chk_q ^ byte_in;
      end
    end
`endif

    // Expiry only fires on byte-free cycles, so a late byte always wins the tie.
    if (timeout_expire) begin
      state_d = ST_IDLE;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= SPR_FROG;
      hi_q    <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`else
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      hi_q    <= hi_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`else
      last_q  <= last_d;
`endif
    end
  end

  assign bus.o_Wr_En   = wr_en_q;
  assign bus.o_Wr_Sel  = sel_q;
  assign bus.o_Wr_Addr = addr_q;
  assign bus.o_Wr_Data = data_q;
  assign bus.o_Busy    = (state_q != ST_IDLE);
  assign bus.o_Done    = done_q;
  assign bus.o_Error   = error_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sprite_loader.sv
// Bench for sprite_loader: random byte gaps and pixels, a frame-level reference model that
// schedules expected writes/done/error per cycle, one per-cycle compare process and literal pins.
module tb_sprite_loader;
  import sprite_loader_pkg::*;

  localparam int TILE = 32;
  localparam int AW   = 10;
  localparam int N    = TILE * TILE;
  localparam int TO   = 100;
  localparam int EW   = 32 + AW + 9;
`ifdef SPRITE_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic i_Clk   = 1'b0;
  logic i_Rst_L = 1'b0;
  int   cyc     = 0;

  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc <= cyc + 1;

  sprite_loader_if #(.ADDR_W(AW)) bus();

  sprite_loader #(
    .TILE_SIZE     (TILE),
    .ADDR_W        (AW),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];   // {cycle, addr, data} of each expected write
  int            done_q[$];
  int            err_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  // Frame-level model: position within the frame, not an FSM copy.
  bit         infr     = 1'b0;
  int         pos      = 0;
  logic       mdl_sel  = 1'b0;
  logic       hi_bit   = 1'b0;
  logic [7:0] acc      = 8'h00;
  int         last_c   = 0;
  bit         busy_cur = 1'b0;
  logic       sel_cur  = 1'b0;

  logic [AW-1:0] hold_addr = '0;
  logic [8:0]    hold_data = '0;
  logic [8:0]    mem_seen[N];
  int            dut_wr_n = 0, dut_done_n = 0, dut_err_n = 0;
  logic [8:0]    pix[N];
  int            gap_max = 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void mdl_reset();
    infr     = 1'b0;
    pos      = 0;
    mdl_sel  = 1'b0;
    acc      = 8'h00;
    busy_cur = 1'b0;
    sel_cur  = 1'b0;
  endfunction

  function automatic void mdl_byte(input logic [7:0] b);
    int i;
    last_c = cyc;
    if (!infr) begin
      if (b == 8'hA5) begin
        infr = 1'b1;
        pos  = 0;
        acc  = 8'h00;
      end
    end else if (pos == 0) begin
      if (b <= 8'h01) begin
        mdl_sel = b[0];
        acc     = acc ^ b;
        pos     = 1;
      end else begin
        err_q.push_back(cyc + 1);
        infr = 1'b0;
      end
    end else if (pos <= 2 * N) begin
      acc = acc ^ b;
      if (pos % 2 == 1) begin
        hi_bit = b[0];
        pos++;
      end else begin
        i = (pos - 2) / 2;
        exp_q.push_back({32'(cyc + 1), AW'(i), hi_bit, b});
        if (i == N - 1 && !CHK_EN) begin
          done_q.push_back(cyc + 2);
          infr = 1'b0;
        end else begin
          pos++;
        end
      end
    end else begin
      if (b == acc) done_q.push_back(cyc + 1);
      else          err_q.push_back(cyc + 1);
      infr = 1'b0;
    end
  endfunction

  function automatic void mdl_cycle(input logic v, input logic [7:0] b);
    busy_cur = infr;
    sel_cur  = mdl_sel;
    if (v) begin
      mdl_byte(b);
    end else if (infr && (cyc - last_c) == TO - 1) begin
      err_q.push_back(cyc + 1);
      infr = 1'b0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic rst, input logic v, input logic [7:0] b);
    @(posedge i_Clk);
    #1;
    i_Rst_L          = rst;
    bus.i_Byte_Valid = v;
    bus.i_Byte       = b;
    if (!rst) mdl_reset();
    else      mdl_cycle(v, b);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    step(1'b1, 1'b1, b);
    idle($urandom_range(0, gap_max));
  endtask

  task automatic send_frame(input logic [7:0] sel, input int npix, input bit rnd_hi,
                            input bit bad_chk, output logic [7:0] x);
    logic [7:0] hi;
    x = sel;
    send_byte(8'hA5);
    send_byte(sel);
    for (int k = 0; k < npix; k++) begin
      hi = {rnd_hi ? 7'($urandom) : 7'd0, pix[k][8]};
      x  = x ^ hi ^ pix[k][7:0];
      send_byte(hi);
      send_byte(pix[k][7:0]);
    end
    if (CHK_EN && npix == N) send_byte(bad_chk ? ~x : x);
  endtask

  // ---------------- compare process ----------------
  always @(negedge i_Clk) begin
    logic [EW-1:0] e;
    bit            exp_wr, exp_done, exp_err;
    if (!i_Rst_L) begin
      check("reset_outputs",
            64'({bus.o_Wr_En, bus.o_Wr_Sel, bus.o_Wr_Addr, bus.o_Wr_Data,
                 bus.o_Busy, bus.o_Done, bus.o_Error}), 64'd0);
      hold_addr = '0;
      hold_data = '0;
      exp_q.delete();
      done_q.delete();
      err_q.delete();
    end else begin
      e      = (exp_q.size() > 0) ? exp_q[0] : '0;
      exp_wr = (exp_q.size() > 0) && (int'(e[EW-1:AW+9]) == cyc);
      check("wr_en", 64'(bus.o_Wr_En), 64'(exp_wr));
      if (exp_wr) begin
        void'(exp_q.pop_front());
        hold_addr = e[AW+8:9];
        hold_data = e[8:0];
      end
      check("wr_addr", 64'(bus.o_Wr_Addr), 64'(hold_addr));
      check("wr_data", 64'(bus.o_Wr_Data), 64'(hold_data));
      check("wr_sel",  64'(bus.o_Wr_Sel),  64'(sel_cur));
      exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
      check("done", 64'(bus.o_Done), 64'(exp_done));
      if (exp_done) void'(done_q.pop_front());
      exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
      check("error", 64'(bus.o_Error), 64'(exp_err));
      if (exp_err) void'(err_q.pop_front());
      check("busy", 64'(bus.o_Busy), 64'(busy_cur));
      if (bus.o_Wr_En) begin
        dut_wr_n++;
        mem_seen[bus.o_Wr_Addr] = bus.o_Wr_Data;
      end
      if (bus.o_Done)  dut_done_n++;
      if (bus.o_Error) dut_err_n++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] x;
    int w0, d0, e0;
    bus.i_Byte_Valid = 1'b0;
    bus.i_Byte       = 8'h00;
    for (int k = 0; k < N; k++) mem_seen[k] = '0;

    repeat (3) step(1'b0, 1'b0, 8'h00);
    idle(3);

    // Garbage in IDLE is dropped.
    send_byte(8'h3C);
    send_byte(8'h77);
    idle(2);
    check("garbage_busy", 64'(bus.o_Busy), 64'd0);

    // Frog ramp frame: pixel k = k mod 512.
    for (int k = 0; k < N; k++) pix[k] = 9'(k % 512);
    w0 = dut_wr_n; d0 = dut_done_n; e0 = dut_err_n;
    send_frame(8'h00, N, 1'b0, 1'b0, x);
    idle(4);
    check("ramp_xor",    64'(x), 64'h00);
    check("ramp_writes", 64'(dut_wr_n - w0), 64'd1024);
    check("ramp_done",   64'(dut_done_n - d0), 64'd1);
    check("ramp_err",    64'(dut_err_n - e0), 64'd0);
    check("ramp_px1023", 64'(mem_seen[1023]), 64'h1FF);
    check("ramp_px300",  64'(mem_seen[300]), 64'h12C);

    // Bad select, then a frame must still be accepted.
    w0 = dut_wr_n; e0 = dut_err_n;
    send_byte(8'hA5);
    send_byte(8'h02);
    idle(3);
    check("badsel_err",    64'(dut_err_n - e0), 64'd1);
    check("badsel_writes", 64'(dut_wr_n - w0), 64'd0);

    // Car frame, random pixels with an embedded sync value at pixel 5, inverted checksum.
    for (int k = 0; k < N; k++) pix[k] = 9'($urandom);
    pix[5] = 9'h0A5;
    w0 = dut_wr_n; d0 = dut_done_n; e0 = dut_err_n;
    send_frame(8'h01, N, 1'b1, 1'b1, x);
    idle(4);
    check("car_writes", 64'(dut_wr_n - w0), 64'd1024);
    check("car_px5",    64'(mem_seen[5]), 64'h0A5);
    check("car_done",   64'(dut_done_n - d0), CHK_EN ? 64'd0 : 64'd1);
    check("car_err",    64'(dut_err_n - e0), CHK_EN ? 64'd1 : 64'd0);

    // Timeout after 10 pixels of silence.
    gap_max = 0;
    w0 = dut_wr_n; e0 = dut_err_n;
    send_frame(8'h00, 10, 1'b1, 1'b0, x);
    idle(TO + 10);
    check("to_err",    64'(dut_err_n - e0), 64'd1);
    check("to_writes", 64'(dut_wr_n - w0), 64'd10);
    check("to_busy",   64'(bus.o_Busy), 64'd0);

    // Byte lands 99 cycles after the previous one: no abort; later silence still aborts.
    e0 = dut_err_n;
    send_frame(8'h00, 10, 1'b0, 1'b0, x);
    idle(TO - 2);
    send_byte(8'h01);
    idle(5);
    check("near_err",  64'(dut_err_n - e0), 64'd0);
    check("near_busy", 64'(bus.o_Busy), 64'd1);
    idle(TO + 5);
    check("near_err_late", 64'(dut_err_n - e0), 64'd1);

    // Reset after pixel 300, then a complete frame.
    gap_max = 1;
    for (int k = 0; k < N; k++) pix[k] = 9'(k % 512);
    e0 = dut_err_n; d0 = dut_done_n;
    send_frame(8'h01, 301, 1'b0, 1'b0, x);
    idle(2);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    idle(2);
    check("rst_no_err",  64'(dut_err_n - e0), 64'd0);
    check("rst_no_done", 64'(dut_done_n - d0), 64'd0);
    w0 = dut_wr_n; d0 = dut_done_n;
    send_frame(8'h00, N, 1'b1, 1'b0, x);
    idle(4);
    check("post_rst_writes", 64'(dut_wr_n - w0), 64'd1024);
    check("post_rst_done",   64'(dut_done_n - d0), 64'd1);
    check("post_rst_px1023", 64'(mem_seen[1023]), 64'h1FF);

    // Random frames back to back with random select.
    gap_max = 2;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < N; k++) pix[k] = 9'($urandom);
      send_frame(8'($urandom_range(0, 1)), N, 1'b1, 1'b0, x);
      idle(3);
    end

    idle(5);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    check("pending_done",   64'(done_q.size()), 64'd0);
    check("pending_err",    64'(err_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_loader.md
Name: sprite_loader

Overview:
- Writer side of the sprite pixel memories read by the display path.
- Receives a framed byte stream from the UART RX block and assembles 9-bit RGB333 pixels.
- Writes them row-major into the frog or car sprite memory write port, so sprites can be replaced at run time without resynthesis.
- Sits between the UART receiver and the write ports of the two sprite Memory instances.

Parameters:
- TILE_SIZE, 32, sprite edge in pixels; pixel count N = TILE_SIZE*TILE_SIZE (1024).
- ADDR_W, 10, write address width; must satisfy 2**ADDR_W >= N.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 2500000, maximum idle clocks between bytes inside a frame (100 ms at 25 MHz).

Ports:
- i_Clk  in  1  system clock; all logic is on the rising edge.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Byte_Valid  in  1  single-cycle strobe; i_Byte is valid this cycle. No backpressure.
- i_Byte  in  8  received byte.
- o_Wr_En  out  1  one-cycle write strobe to sprite memory.
- o_Wr_Sel  out  1  target sprite: 0 = frog, 1 = car.
- o_Wr_Addr  out  ADDR_W  pixel address, row*TILE_SIZE + col.
- o_Wr_Data  out  9  pixel: [8:6] R, [5:3] G, [2:0] B.
- o_Busy  out  1  high while a frame is in progress (any state except IDLE).
- o_Done  out  1  one-cycle pulse when a frame completes successfully.
- o_Error  out  1  one-cycle pulse when a frame is aborted or fails its check.

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0; state returns to IDLE; pixel counter, checksum and timeout counter clear.
- Frame format: SYNC_BYTE, SEL, then N pixel pairs (HI, LO), then CHK (CHK only when the optional feature is enabled).
  - HI[0] = pixel[8]; HI[7:1] are ignored.
  - LO = pixel[7:0].
- States:
  - IDLE: a byte equal to SYNC_BYTE moves to SEL. Any other byte is dropped silently.
  - SEL: a byte of 8'h00 or 8'h01 latches o_Wr_Sel = byte[0], clears the pixel counter and moves to PIX_HI. Any other value pulses o_Error and returns to IDLE.
  - PIX_HI: stores HI[0] and moves to PIX_LO.
  - PIX_LO: forms the pixel and writes it (see write timing), then:
    - if counter == N-1, moves to CHK when the feature is enabled, otherwise pulses o_Done and returns to IDLE;
    - otherwise increments the counter and moves to PIX_HI.
  - CHK: see Optional Feature.
- Write timing: o_Wr_En is high exactly in the cycle after the LO byte is accepted. o_Wr_Addr and o_Wr_Data are stable that cycle and hold their values afterwards. o_Wr_Sel is constant for the whole frame.
- Sync inside a frame: SYNC_BYTE seen in any state other than IDLE is treated as data. There is no resynchronisation mid-frame.
- Timeout:
  - The counter resets on every i_Byte_Valid and counts only while not in IDLE.
  - Reaching TIMEOUT_CYCLES-1 pulses o_Error and returns to IDLE.
  - If a byte strobe and timeout expiry fall in the same cycle, the byte wins: it is processed and the counter clears.
- Partial frames: pixels already written are not rolled back. Memory holds a mix of old and new data after an aborted frame.
- Done/Error: o_Done and o_Error are never high in the same cycle. Both are one cycle wide. The state is IDLE in the cycle they are high, so a new SYNC in the next cycle is accepted.
- Widths: the pixel counter is ADDR_W bits and never wraps, because the frame ends at N-1.
- Reset mid-frame: abandons the frame with no o_Error pulse.

Optional Feature:
- Macro: SPRITE_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR is accumulated over SEL and every HI and LO byte; it is cleared on SYNC.
  - In CHK, the received byte is compared with the accumulator. Match pulses o_Done; mismatch pulses o_Error. Either way the state returns to IDLE.
- Undefined: there is no CHK state or accumulator logic, and o_Done pulses in the cycle after the final write.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SEL, PIX_HI, PIX_LO, CHK);
  - the sprite select constants SPR_FROG = 0 and SPR_CAR = 1;
  - the RGB333 field slice constants, also used by the display block.
- One natural sub-module: sprite_loader_timeout, a loadable down-counter with clear and expire outputs. Everything else stays in one module.

Test Plan:
- Normal frame, feature on: A5, 00, then 1024 pairs with pixel k = k mod 512, then correct XOR -> 1024 o_Wr_En pulses, addr 0..1023, data matching, o_Wr_Sel = 0, one o_Done, no o_Error.
- Bad select: A5, 02 -> o_Error one cycle after the 02 byte; no writes; the next A5 is accepted.
- Bad checksum: car frame (SEL 01) with CHK inverted -> all 1024 writes occur with o_Wr_Sel = 1, then o_Error and no o_Done.
- Timeout: A5, 00, 10 pixel pairs, then silence for TIMEOUT_CYCLES (test value 100) -> o_Error at exactly cycle 100 after the last byte; o_Busy drops.
  - Repeat with a byte arriving at cycle 99 -> no error.
- Embedded sync and boundary: pixel 5 = 9'h0A5 (HI 00, LO A5) -> written as data at addr 5.
  - Garbage 3C, 77 in IDLE -> ignored, o_Busy stays 0.
- Reset mid-frame: i_Rst_L low for 2 cycles after pixel 300 -> all outputs 0, no pulses; a following full frame writes addr 0..1023 correctly.
